// File: rtl/mem_pkg.sv
// Shared definitions for the variable-latency MEM stage: load encodings and default widths.
package mem_pkg;

    typedef enum logic [2:0] {
        LOAD_W  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_BU = 3'd2,
        LOAD_H  = 3'd3,
        LOAD_HU = 3'd4,
        LOAD_WL = 3'd5,
        LOAD_WR = 3'd6
    } load_op_e;

    localparam int unsigned SIDE_W_DEFAULT   = 64;
    localparam int unsigned CANCEL_W_DEFAULT = 2;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sign);
        return {{24{sign & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sign);
        return {{16{sign & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_vlat_if.sv
// EXE->MEM->WB handshake, data response and flush signals of the MEM stage.
interface mem_stage_vlat_if #(
    parameter int unsigned SIDE_W = 64
);
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic [31:0]       es_pc;
    logic [31:0]       es_alu_result;
    logic [31:0]       es_rt_value;
    logic [2:0]        es_load_op;
    logic              es_res_from_mem;
    logic              es_req_issued;
    logic              es_gr_we;
    logic [4:0]        es_dest;
    logic              es_ex;
    logic [SIDE_W-1:0] es_side;

    logic              data_ok;
    logic [31:0]       data_rdata;
    logic              flush;
    logic              ws_allowin;

    logic              ms_to_ws_valid;
    logic [31:0]       ms_pc;
    logic              ms_gr_we;
    logic [4:0]        ms_dest;
    logic [31:0]       ms_result;
    logic [SIDE_W-1:0] ms_side;
    logic              ms_ex;
    logic [4:0]        ms_fwd_dest;
    logic              ms_fwd_ready;
    logic              ms_cancel_busy;

    // Environment side: EXE, data cache and WB.
    modport master (
        output es_to_ms_valid, es_pc, es_alu_result, es_rt_value, es_load_op,
               es_res_from_mem, es_req_issued, es_gr_we, es_dest, es_ex, es_side,
               data_ok, data_rdata, flush, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_side,
               ms_ex, ms_fwd_dest, ms_fwd_ready, ms_cancel_busy
    );

    // The MEM stage itself.
    modport slave (
        input  es_to_ms_valid, es_pc, es_alu_result, es_rt_value, es_load_op,
               es_res_from_mem, es_req_issued, es_gr_we, es_dest, es_ex, es_side,
               data_ok, data_rdata, flush, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_side,
               ms_ex, ms_fwd_dest, ms_fwd_ready, ms_cancel_busy
    );

endinterface

// File: rtl/load_align.sv
// Load data alignment: byte/half extraction with extension and lwl/lwr merge with rt.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] src,
    input  logic [31:0] rt,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_op,
    output logic [31:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = src[7:0];
            2'd1:    byte_sel = src[15:8];
            2'd2:    byte_sel = src[23:16];
            default: byte_sel = src[31:24];
        endcase
        half_sel = addr[1] ? src[31:16] : src[15:0];

        aligned = src;
        case (load_op_e'(load_op))
            LOAD_B:  aligned = ext8(byte_sel, 1'b1);
            LOAD_BU: aligned = ext8(byte_sel, 1'b0);
            // Odd halfword addresses fault upstream; return zero rather than garbage.
            LOAD_H:  aligned = addr[0] ? 32'd0 : ext16(half_sel, 1'b1);
            LOAD_HU: aligned = addr[0] ? 32'd0 : ext16(half_sel, 1'b0);
            LOAD_WL: begin
                case (addr)
                    2'd0:    aligned = {src[7:0], rt[23:0]};
                    2'd1:    aligned = {src[15:0], rt[15:0]};
                    2'd2:    aligned = {src[23:0], rt[7:0]};
                    default: aligned = src;
                endcase
            end
            LOAD_WR: begin
                case (addr)
                    2'd0:    aligned = src;
                    2'd1:    aligned = {rt[31:24], src[31:8]};
                    2'd2:    aligned = {rt[31:16], src[31:16]};
                    default: aligned = {rt[31:8], src[31:24]};
                endcase
            end
            default: aligned = src;
        endcase
    end

endmodule

// File: rtl/mem_stage_vlat.sv
// MEM pipeline stage for variable-latency data responses: holds one instruction, buffers
// early responses while WB stalls, and discards responses owed to flushed requests.
module mem_stage_vlat
    import mem_pkg::*;
#(
    parameter int unsigned SIDE_W   = SIDE_W_DEFAULT,
    parameter int unsigned CANCEL_W = CANCEL_W_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    mem_stage_vlat_if.slave bus
);

    localparam int unsigned CntW      = CANCEL_W + 1;
    localparam int unsigned CancelMax = (1 << CANCEL_W) - 1;

    logic                ms_valid_q;
    logic                buf_valid_q;
    logic [31:0]         rbuf_q;
    logic [CANCEL_W-1:0] cancel_cnt_q;
    logic [CANCEL_W-1:0] cancel_cnt_d;

    logic [31:0]         pc_q;
    logic [31:0]         alu_result_q;
    logic [31:0]         rt_value_q;
    logic [2:0]          load_op_q;
    logic                res_from_mem_q;
    logic                req_issued_q;
    logic                gr_we_q;
    logic [4:0]          dest_q;
    logic                ex_q;
    logic [SIDE_W-1:0]   side_q;

    logic                cancel_busy;
    logic                resp_live;
    logic                resp_drop;
    logic                waiting;
    logic                ready_go;
    logic                allowin;
    logic                to_ws_valid;
    logic                capture;
    logic [1:0]          inc;
    logic [CntW-1:0]     cnt_sum;
    logic [31:0]         load_src;
    logic [31:0]         load_data;

    assign cancel_busy = (cancel_cnt_q != '0);
    assign resp_live   = bus.data_ok && !cancel_busy;
    assign resp_drop   = bus.data_ok && cancel_busy;
    assign waiting     = ms_valid_q && req_issued_q && !buf_valid_q;
    assign ready_go    = !req_issued_q || buf_valid_q || resp_live;
    assign allowin     = !ms_valid_q || (ready_go && bus.ws_allowin);
    assign to_ws_valid = ms_valid_q && ready_go && !bus.flush;
    assign capture     = bus.es_to_ms_valid && allowin && !bus.flush;

    // On flush every request still in flight becomes a response to discard: the one this
    // stage is waiting on (unless it lands this very cycle) and one EXE issues right now.
    always_comb begin
        inc = {1'b0, waiting && !resp_live}
            + {1'b0, bus.es_to_ms_valid && allowin && bus.es_req_issued};
        cnt_sum = {1'b0, cancel_cnt_q} - CntW'(resp_drop);
        if (bus.flush) begin
            cnt_sum = cnt_sum + CntW'(inc);
        end
        cancel_cnt_d = cnt_sum[CANCEL_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q     <= 1'b0;
            buf_valid_q    <= 1'b0;
            rbuf_q         <= '0;
            cancel_cnt_q   <= '0;
            pc_q           <= '0;
            alu_result_q   <= '0;
            rt_value_q     <= '0;
            load_op_q      <= '0;
            res_from_mem_q <= 1'b0;
            req_issued_q   <= 1'b0;
            gr_we_q        <= 1'b0;
            dest_q         <= '0;
            ex_q           <= 1'b0;
            side_q         <= '0;
        end else begin
            if (allowin) begin
                ms_valid_q <= bus.es_to_ms_valid && !bus.flush;
            end else if (bus.flush) begin
                ms_valid_q <= 1'b0;
            end

            if (bus.flush || capture) begin
                buf_valid_q <= 1'b0;
            end else if (resp_live && waiting && !(to_ws_valid && bus.ws_allowin)) begin
                buf_valid_q <= 1'b1;
                rbuf_q      <= bus.data_rdata;
            end

            cancel_cnt_q <= cancel_cnt_d;

            if (capture) begin
                pc_q           <= bus.es_pc;
                alu_result_q   <= bus.es_alu_result;
                rt_value_q     <= bus.es_rt_value;
                load_op_q      <= bus.es_load_op;
                res_from_mem_q <= bus.es_res_from_mem;
                req_issued_q   <= bus.es_req_issued;
                gr_we_q        <= bus.es_gr_we;
                dest_q         <= bus.es_dest;
                ex_q           <= bus.es_ex;
                side_q         <= bus.es_side;
            end
        end
    end

    // A zero-wait response is consumed straight off the bus.
    assign load_src = buf_valid_q ? rbuf_q : bus.data_rdata;

    load_align u_load_align (
        .src     (load_src),
        .rt      (rt_value_q),
        .addr    (alu_result_q[1:0]),
        .load_op (load_op_q),
        .aligned (load_data)
    );

    assign bus.ms_allowin     = allowin;
    assign bus.ms_to_ws_valid = to_ws_valid;
    assign bus.ms_pc          = pc_q;
    assign bus.ms_gr_we       = gr_we_q;
    assign bus.ms_dest        = dest_q;
    assign bus.ms_result      = res_from_mem_q ? load_data : alu_result_q;
    assign bus.ms_side        = side_q;
    assign bus.ms_ex          = ms_valid_q && ex_q;
    assign bus.ms_fwd_dest    = (ms_valid_q && gr_we_q) ? dest_q : 5'd0;
    assign bus.ms_fwd_ready   = !res_from_mem_q || buf_valid_q || resp_live;
    assign bus.ms_cancel_busy = cancel_busy;

    a_resp_when_waiting : assert property (@(posedge clk) disable iff (reset)
        resp_live |-> waiting);

    a_cancel_no_overflow : assert property (@(posedge clk) disable iff (reset)
        cnt_sum <= CntW'(CancelMax));

    a_ex_no_request : assert property (@(posedge clk) disable iff (reset)
        (bus.es_to_ms_valid && bus.es_ex) |-> !bus.es_req_issued);

endmodule

// File: tb/tb_mem_stage_vlat.sv
// Randomised scoreboard bench for mem_stage_vlat with an in-order memory model.
module tb_mem_stage_vlat;
    import mem_pkg::*;

    localparam int unsigned SideW   = 64;
    localparam int          NCycles = 4000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [2:0]  op;
        logic        mem;
        logic        we;
        logic        ex;
        logic [4:0]  dest;
        logic [63:0] side;
    } instr_t;

    typedef struct packed {
        logic        sq;
        logic [31:0] data;
        int          ready;
    } mreq_t;

    typedef struct packed {
        instr_t      i;
        logic [31:0] d;
        int          lat;
    } dir_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic        we;
        logic        ex;
        logic [4:0]  dest;
        logic [63:0] side;
    } out_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_stage_vlat_if #(.SIDE_W(SideW)) bus ();

    mem_stage_vlat #(
        .SIDE_W   (SideW),
        .CANCEL_W (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: the instruction in MEM and the memory's outstanding requests.
    logic        m_valid = 1'b0;
    logic        m_has = 1'b0;
    logic [31:0] m_data = '0;
    instr_t      m_ins = '0;
    mreq_t       memq[$];
    out_t        expq[$];
    dir_t        dirq[$];
    logic        exe_valid = 1'b0;
    instr_t      exe_ins = '0;
    logic [31:0] exe_dat = '0;
    int          exe_lat = 1;
    int          cyc = 0;
    logic        reset_armed = 1'b0;
    out_t        mo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] src,
                                             input logic [31:0] rt, input logic [31:0] addr);
        int          a = int'(addr[1:0]);
        int          sh = 8 * a;
        logic [63:0] s = {32'b0, src};
        logic [63:0] r = {32'b0, rt};
        logic [7:0]  b = 8'(src >> sh);
        logic [15:0] h = 16'(src >> sh);
        case (op)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'b0, b};
            3'd3:    return (a % 2 != 0) ? 32'd0 : {{16{h[15]}}, h};
            3'd4:    return (a % 2 != 0) ? 32'd0 : {16'b0, h};
            3'd5:    return 32'((s << (8 * (3 - a))) | (r & ((64'd1 << (8 * (3 - a))) - 64'd1)));
            3'd6:    return 32'((s >> sh) | (r & ~(64'hFFFF_FFFF >> sh) & 64'hFFFF_FFFF));
            default: return src;
        endcase
    endfunction

    function automatic instr_t gen();
        instr_t x;
        x.pc   = $urandom;
        x.alu  = $urandom;
        x.rt   = $urandom;
        x.op   = 3'($urandom_range(0, 6));
        x.mem  = ($urandom_range(0, 3) != 0);
        x.we   = ($urandom_range(0, 5) != 0);
        x.dest = 5'($urandom);
        x.side = {$urandom, $urandom};
        x.ex   = !x.mem && ($urandom_range(0, 9) == 0);
        return x;
    endfunction

    function automatic dir_t mk(input logic [2:0] op, input logic mem, input logic [31:0] alu,
                                input logic [31:0] rt, input logic [31:0] d, input int lat);
        dir_t t;
        t.i      = gen();
        t.i.op   = op;
        t.i.mem  = mem;
        t.i.ex   = 1'b0;
        t.i.alu  = alu;
        t.i.rt   = rt;
        t.d      = d;
        t.lat    = lat;
        return t;
    endfunction

    task automatic drive_idle();
        bus.es_to_ms_valid  = 1'b0;
        bus.es_pc           = '0;
        bus.es_alu_result   = '0;
        bus.es_rt_value     = '0;
        bus.es_load_op      = '0;
        bus.es_res_from_mem = 1'b0;
        bus.es_req_issued   = 1'b0;
        bus.es_gr_we        = 1'b0;
        bus.es_dest         = '0;
        bus.es_ex           = 1'b0;
        bus.es_side         = '0;
        bus.data_ok         = 1'b0;
        bus.data_rdata      = '0;
        bus.flush           = 1'b0;
        bus.ws_allowin      = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_to_ws_valid"}, 64'(bus.ms_to_ws_valid), 64'd0);
        check({tag, "_allowin"}, 64'(bus.ms_allowin), 64'd1);
        check({tag, "_fwd_dest"}, 64'(bus.ms_fwd_dest), 64'd0);
        check({tag, "_cancel_busy"}, 64'(bus.ms_cancel_busy), 64'd0);
    endtask

    // Reset lands between clock edges while a load is outstanding.
    task automatic async_reset();
        drive_idle();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #3;
        reset = 1'b0;
        m_valid   = 1'b0;
        m_has     = 1'b0;
        exe_valid = 1'b0;
        memq.delete();
    endtask

    task automatic step();
        logic        flush_c, ws_c, ok_c, live_c, ready_e, to_ws_e, allow_e, busy_e;
        logic [31:0] live_d, src;
        mreq_t       e;
        dir_t        d;
        out_t        o;
        int          nsq;

        if (!exe_valid && $urandom_range(0, 3) != 0) begin
            exe_valid = 1'b1;
            if (dirq.size() > 0) begin
                d       = dirq.pop_front();
                exe_ins = d.i;
                exe_dat = d.d;
                exe_lat = d.lat;
            end else begin
                exe_ins = gen();
                exe_dat = $urandom;
                exe_lat = $urandom_range(1, 4);
            end
        end

        nsq = 0;
        foreach (memq[k]) if (memq[k].sq) nsq++;
        busy_e  = (nsq > 0);
        flush_c = (cyc > 60) && (nsq <= 1) && ($urandom_range(0, 24) == 0);
        ws_c    = ($urandom_range(0, 3) != 0);
        ok_c    = (memq.size() > 0) && (memq[0].ready <= cyc);
        live_c  = 1'b0;
        live_d  = $urandom;
        if (ok_c) begin
            e      = memq.pop_front();
            live_d = e.data;
            live_c = !e.sq;
        end

        bus.es_to_ms_valid  = exe_valid;
        bus.es_pc           = exe_ins.pc;
        bus.es_alu_result   = exe_ins.alu;
        bus.es_rt_value     = exe_ins.rt;
        bus.es_load_op      = exe_ins.op;
        bus.es_res_from_mem = exe_ins.mem;
        bus.es_req_issued   = exe_ins.mem;
        bus.es_gr_we        = exe_ins.we;
        bus.es_dest         = exe_ins.dest;
        bus.es_ex           = exe_ins.ex;
        bus.es_side         = exe_ins.side;
        bus.data_ok         = ok_c;
        bus.data_rdata      = live_d;
        bus.flush           = flush_c;
        bus.ws_allowin      = ws_c;

        ready_e = m_valid && (!m_ins.mem || m_has || live_c);
        to_ws_e = ready_e && !flush_c;
        allow_e = !m_valid || (ready_e && ws_c);
        if (to_ws_e && ws_c) begin
            src    = m_has ? m_data : live_d;
            o.pc   = m_ins.pc;
            o.res  = m_ins.mem ? ref_load(m_ins.op, src, m_ins.rt, m_ins.alu) : m_ins.alu;
            o.we   = m_ins.we;
            o.ex   = m_ins.ex;
            o.dest = m_ins.dest;
            o.side = m_ins.side;
            expq.push_back(o);
        end

        @(negedge clk);
        check("allowin", 64'(bus.ms_allowin), 64'(allow_e));
        check("to_ws_valid", 64'(bus.ms_to_ws_valid), 64'(to_ws_e));
        check("cancel_busy", 64'(bus.ms_cancel_busy), 64'(busy_e));
        check("fwd_dest", 64'(bus.ms_fwd_dest), 64'((m_valid && m_ins.we) ? m_ins.dest : 5'd0));
        if (m_valid) begin
            check("fwd_ready", 64'(bus.ms_fwd_ready), 64'(!m_ins.mem || m_has || live_c));
        end

        if (flush_c) begin
            foreach (memq[k]) memq[k].sq = 1'b1;
            if (exe_valid && allow_e && exe_ins.mem) begin
                e.sq    = 1'b1;
                e.data  = exe_dat;
                e.ready = cyc + exe_lat;
                memq.push_back(e);
            end
            m_valid   = 1'b0;
            m_has     = 1'b0;
            exe_valid = 1'b0;
        end else begin
            if (live_c && !(to_ws_e && ws_c)) begin
                m_has  = 1'b1;
                m_data = live_d;
            end
            if (allow_e) begin
                m_valid = exe_valid;
                m_has   = 1'b0;
                if (exe_valid) begin
                    m_ins = exe_ins;
                    if (exe_ins.mem) begin
                        e.sq    = 1'b0;
                        e.data  = exe_dat;
                        e.ready = cyc + exe_lat;
                        memq.push_back(e);
                    end
                    exe_valid = 1'b0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.ms_to_ws_valid && bus.ws_allowin) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: pc %h result %h, nothing expected",
                         bus.ms_pc, bus.ms_result);
            end else begin
                mo = expq.pop_front();
                check("out_pc", 64'(bus.ms_pc), 64'(mo.pc));
                check("out_result", 64'(bus.ms_result), 64'(mo.res));
                check("out_dest", 64'(bus.ms_dest), 64'(mo.dest));
                check("out_gr_we", 64'(bus.ms_gr_we), 64'(mo.we));
                check("out_ex", 64'(bus.ms_ex), 64'(mo.ex));
                check("out_side", bus.ms_side, mo.side);
            end
        end
    end

    initial begin
        drive_idle();
        reset = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #3;
        reset = 1'b0;

        dirq.push_back(mk(3'd1, 1'b1, 32'h8000_0002, 32'h0, 32'h8899_AABB, 1));
        dirq.push_back(mk(3'd2, 1'b1, 32'h8000_0002, 32'h0, 32'h8899_AABB, 1));
        dirq.push_back(mk(3'd0, 1'b1, 32'h8000_1000, 32'h0, 32'h1357_9BDF, 4));
        dirq.push_back(mk(3'd5, 1'b1, 32'h8000_2001, 32'h1122_3344, 32'hAABB_CCDD, 1));
        dirq.push_back(mk(3'd6, 1'b1, 32'h8000_2003, 32'h1122_3344, 32'hAABB_CCDD, 2));
        dirq.push_back(mk(3'd0, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 1));

        for (int c = 0; c < NCycles; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (c == 1200 || c == 2600) reset_armed = 1'b1;
            if (reset_armed && m_valid && m_ins.mem && !m_has) begin
                reset_armed = 1'b0;
                async_reset();
                continue;
            end
            step();
        end

        check("leftover_expected", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_vlat.md
Name: mem_stage_vlat

Overview:
- Parametrised successor of the MEM pipeline stage for the AXI/DCache build; memory responses arrive with variable latency.
- Holds one instruction whose data request was accepted in EXE, then waits for data_ok and aligns load data (lb/lbu/lh/lhu/lw/lwl/lwr).
- Buffers a response that arrives while WB is stalled.
- After a flush, discards responses still owed to squashed requests, using a cancel counter.

Parameters:
SIDE_W, 64, width of pass-through sideband (cp0 sel/rd, ExcCode, bd, eret/mtc0/mfc0 flags, bad vaddr)
CANCEL_W, 2, width of cancel counter (max 2^CANCEL_W-1 discards pending)

Ports:
clk in 1 clock
reset in 1 asynchronous active-high reset
es_to_ms_valid in 1 EXE has an instruction
ms_allowin out 1 MEM can accept
es_pc in 32 instruction PC
es_alu_result in 32 ALU result / data address
es_rt_value in 32 rt for lwl/lwr merge
es_load_op in 3 load type (package encoding)
es_res_from_mem in 1 result comes from memory
es_req_issued in 1 data request accepted (addr_ok) in EXE
es_gr_we in 1 RF write enable
es_dest in 5 RF write address
es_ex in 1 exception tagged
es_side in SIDE_W sideband
data_ok in 1 read response valid
data_rdata in 32 response data
flush in 1 exception/eret flush from WB
ws_allowin in 1 WB can accept
ms_to_ws_valid out 1 valid to WB
ms_pc out 32 ; ms_gr_we out 1 ; ms_dest out 5 ; ms_result out 32 ; ms_side out SIDE_W ; ms_ex out 1
ms_fwd_dest out 5 dest for ID bypass, 0 when not valid or not writing
ms_fwd_ready out 1 ms_result valid for bypass (0 = ID stalls on match)
ms_cancel_busy out 1 cancel counter nonzero

Behaviour:
- Reset (async) state:
  - ms_valid=0, buf_valid=0, cancel_cnt=0, all payload registers 0.
  - Hence ms_to_ws_valid=0, ms_allowin=1, ms_fwd_dest=0, ms_cancel_busy=0.
- Capture: when es_to_ms_valid && ms_allowin && !flush, latch all es_* fields and set buf_valid=0.
- ms_valid update: if ms_allowin, ms_valid <= es_to_ms_valid && !flush; otherwise on flush, ms_valid <= 0.
- Response classification:
  - resp_live = data_ok && cancel_cnt==0.
  - If cancel_cnt>0, data_ok decrements the counter and the data is dropped.
- Waiting: waiting = ms_valid && req_issued && !buf_valid.
- ms_ready_go = !req_issued || buf_valid || resp_live.
- Response buffering: if resp_live && waiting && !(ms_to_ws_valid && ws_allowin), store data_rdata in rbuf and set buf_valid=1.
  - Zero-latency path: data is used directly from data_rdata in the same cycle.
- resp_live while not waiting is a protocol violation; flag it with an assertion.
- Handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
- Load data selection: src = buf_valid ? rbuf : data_rdata; a = alu_result[1:0].
- Load alignment:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: a=0 gives bits 15:0, a=2 gives bits 31:16; a=1/3 gives 0 (AdEL is raised upstream).
  - LWL: a=0 {src[7:0],rt[23:0]}; a=1 {src[15:0],rt[15:0]}; a=2 {src[23:0],rt[7:0]}; a=3 src.
  - LWR: a=0 src; a=1 {rt[31:24],src[31:8]}; a=2 {rt[31:16],src[31:16]}; a=3 {rt[31:8],src[31:24]}.
  - LW: src.
- ms_result = res_from_mem ? aligned : alu_result.
- Bypass:
  - ms_fwd_dest = dest gated by ms_valid && gr_we.
  - ms_fwd_ready = !res_from_mem || buf_valid || resp_live.
- Flush:
  - ms_valid<=0 and buf_valid<=0.
  - inc = (waiting && !resp_live) + (es_to_ms_valid && ms_allowin && es_req_issued); inc is in 0..2.
  - cancel_cnt <= cancel_cnt + inc - (data_ok && cancel_cnt>0).
  - A live response in the flush cycle is consumed and not counted.
- Overflow: cancel_cnt must never exceed its maximum; assert. The counter does not saturate.
- Exceptions: es_ex implies !es_req_issued (EXE suppresses the request); ms_ex = ms_valid && ex.
- Responses are in order. New requests may issue while ms_cancel_busy=1; the oldest responses are the ones dropped.

Decomposition:
- Package mem_pkg:
  - LOAD_W=3'd0, LOAD_B=1, LOAD_BU=2, LOAD_H=3, LOAD_HU=4, LOAD_WL=5, LOAD_WR=6.
  - Default SIDE_W and CANCEL_W.
- Sub-module load_align (purely combinational): inputs src, rt, addr[1:0], load_op; output 32-bit aligned value.
- Stage FSM, buffer and cancel counter live in mem_stage_vlat.

Test Plan:
1. LB, alu_result=0x80000002, rdata=0x8899AABB with data_ok in the capture+1 cycle, ws_allowin=1 -> ms_result=0xFFFFFF99, ms_to_ws_valid high 1 cycle; with LBU -> 0x00000099.
2. LW with data_ok 3 cycles late -> ms_to_ws_valid=0 and ms_allowin=0 for 3 cycles, ms_fwd_ready=0; then result equals rdata.
3. LWL, addr low bits 1, rt=0x11223344, rdata=0xAABBCCDD, data_ok while ws_allowin=0 -> buf_valid=1; on ws_allowin=1 the result is 0xCCDD3344 even though data_rdata has since changed.
4. Flush while a load waits -> cancel_cnt=1, ms_cancel_busy=1; next data_ok dropped and cnt returns to 0; next load's data_ok is accepted with correct data.
5. Flush with a waiting load plus an incoming issued load -> cnt=2; two data_ok dropped; a simultaneous flush and dropped data_ok with inc=1 leaves cnt unchanged.
6. Assert reset asynchronously mid-wait (off clock edge) -> ms_to_ws_valid=0, ms_allowin=1, cnt=0 immediately; a non-load ALU op then passes with 1-cycle latency.
